dec_ex_stage: RTL and testbench
===============================

// Module: dec_ex_stage
// PURPOSE
//  DEC/EX pipeline register with integrated load-use hazard detection for the 5-stage RISC-V core.
//  Captures decoded operands/control each cycle and presents dec_ex_* to the EX stage and forwarding logic.
//  Stalls decode and inserts bubbles when an instruction in DEC needs a load result still in EX.
//  Loads are forwarded only from MEM/WB; EX/MEM cannot supply load data.
//  Squashes the captured instruction on a branch/jump flush from EX.
// PARAMETERS
//  XLEN            32  datapath width (pc, register data, immediate)
//  CTRL_W          8   width of opaque EX/MEM/WB control bundle passed through
//  LOAD_USE_STALL  1   bubbles inserted per load-use hazard; legal 1..7
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       synchronous, active-high reset
//  dec_valid       in   1       DEC holds a real instruction
//  dec_pc          in   XLEN    PC of DEC instruction
//  dec_rs1_ad      in   5       source register 1 address
//  dec_rs2_ad      in   5       source register 2 address
//  dec_rd_ad       in   5       destination register address
//  dec_uses_rs1    in   1       instruction reads rs1
//  dec_uses_rs2    in   1       instruction reads rs2
//  dec_rs1_data    in   XLEN    register file read data 1
//  dec_rs2_data    in   XLEN    register file read data 2
//  dec_imm         in   XLEN    sign-extended immediate
//  dec_ctrl        in   CTRL_W  pass-through control bundle
//  dec_rdEn        in   1       instruction writes rd
//  dec_memRd       in   1       instruction is a load
//  flush_ex        in   1       EX resolved taken branch/jump; kill DEC instruction
//  dec_ex_*        out  -       registered copies of every dec_* input above except dec_uses_rs1/rs2 (same widths)
//  stall_fd        out  1       hold PC and IF/DEC register this cycle (combinational)
// BEHAVIOUR
//  - Reset: every dec_ex_* output 0; state RUN; cnt 0; stall_fd 0.
//  - States: RUN, STALL. cnt is 3 bits.
//  - hazard = dec_ex_valid & dec_ex_memRd & dec_ex_rdEn & (dec_ex_rd_ad!=0) & dec_valid &
//    ((dec_uses_rs1 & dec_rs1_ad==dec_ex_rd_ad) | (dec_uses_rs2 & dec_rs2_ad==dec_ex_rd_ad)).
//  - stall_fd = !flush_ex & (hazard | state==STALL).
//  - Bubble = all dec_ex_* outputs loaded with 0. dec_ex_valid, dec_ex_rdEn, dec_ex_memRd are 0.
//    dec_ex_rs*_ad are 0, so downstream forwarding logic does not match on a bubble.
//  - Priority at each edge: rst > flush_ex > stall > normal capture.
//  - flush_ex=1: load bubble; state RUN; cnt 0. flush_ex overrides a pending stall.
//  - RUN & hazard:
//    - Load bubble.
//    - If LOAD_USE_STALL>1: go STALL with cnt=LOAD_USE_STALL-1.
//    - Else: stay RUN.
//  - STALL:
//    - Load bubble and decrement cnt.
//    - When cnt==1 at the edge, go RUN.
//    - DEC inputs are ignored in STALL; they are re-evaluated in RUN.
//  - Total stall_fd-high cycles per hazard = LOAD_USE_STALL.
//  - RUN, no hazard, dec_valid=1: capture all dec_* into dec_ex_*.
//  - RUN, no hazard, dec_valid=0: load bubble. Never propagate control from an invalid slot.
//  - A hazard is detected against a load in EX only. A load two ahead has reached MEM and is
//    handled by the forwarding logic; no stall for it.
//  - rd=x0 loads never stall. Non-load writers never stall.
//  - No internal combinational path from dec_ex_* to dec_* inputs, so there is no loop through stall_fd.
// TESTING
//  1. rst=1 two cycles with random inputs -> all dec_ex_* =0, stall_fd=0; after release, capture on next edge.
//  2. lw x5 in EX, then add x6,x5,x7 in DEC (uses_rs1):
//     - stall_fd=1 for 1 cycle; next dec_ex_valid=0.
//     - Following cycle, add captured with dec_ex_rs1_ad=5.
//  3. LOAD_USE_STALL=3, same pair -> stall_fd high exactly 3 cycles, 3 bubbles, then add captured.
//  4. lw x0 in EX and add using x0; also lw x5 with DEC uses_rs2=0, rs2_ad=5 -> no stall either case.
//  5. Hazard cycle with flush_ex=1 -> stall_fd=0, bubble loaded, state RUN; next cycle captures new DEC.
//  6. flush_ex=1 mid-STALL (LOAD_USE_STALL=3, cycle 2) -> stall drops that cycle; pipeline resumes next edge.

Source files
------------

// File: rtl/dec_ex_stage.sv
// DEC/EX pipeline register with load-use hazard detection.
// A load in EX stalls a dependent DEC instruction for LOAD_USE_STALL cycles, and a flush from EX squashes DEC.
module dec_ex_stage #(
  parameter int XLEN           = 32,
  parameter int CTRL_W         = 8,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic [4:0]        dec_rs1_ad,
  input  logic [4:0]        dec_rs2_ad,
  input  logic [4:0]        dec_rd_ad,
  input  logic              dec_uses_rs1,
  input  logic              dec_uses_rs2,
  input  logic [XLEN-1:0]   dec_rs1_data,
  input  logic [XLEN-1:0]   dec_rs2_data,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic              dec_rdEn,
  input  logic              dec_memRd,
  input  logic              flush_ex,
  output logic              dec_ex_valid,
  output logic [XLEN-1:0]   dec_ex_pc,
  output logic [4:0]        dec_ex_rs1_ad,
  output logic [4:0]        dec_ex_rs2_ad,
  output logic [4:0]        dec_ex_rd_ad,
  output logic [XLEN-1:0]   dec_ex_rs1_data,
  output logic [XLEN-1:0]   dec_ex_rs2_data,
  output logic [XLEN-1:0]   dec_ex_imm,
  output logic [CTRL_W-1:0] dec_ex_ctrl,
  output logic              dec_ex_rdEn,
  output logic              dec_ex_memRd,
  output logic              stall_fd
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1_ad;
    logic [4:0]        rs2_ad;
    logic [4:0]        rd_ad;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic              rdEn;
    logic              memRd;
  } ex_pkt_t;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  ex_pkt_t    dec_pkt;
  ex_pkt_t    ex_q;
  logic [0:0] state;
  logic [2:0] cnt;
  logic       hazard;

  always_comb begin
    dec_pkt          = '0;
    dec_pkt.valid    = dec_valid;
    dec_pkt.pc       = dec_pc;
    dec_pkt.rs1_ad   = dec_rs1_ad;
    dec_pkt.rs2_ad   = dec_rs2_ad;
    dec_pkt.rd_ad    = dec_rd_ad;
    dec_pkt.rs1_data = dec_rs1_data;
    dec_pkt.rs2_data = dec_rs2_data;
    dec_pkt.imm      = dec_imm;
    dec_pkt.ctrl     = dec_ctrl;
    dec_pkt.rdEn     = dec_rdEn;
    dec_pkt.memRd    = dec_memRd;
  end

  // Only a load sitting in EX can't be forwarded in time; anything further ahead is covered by MEM/WB forwarding.
  assign hazard = ex_q.valid & ex_q.memRd & ex_q.rdEn & (ex_q.rd_ad != 5'd0) & dec_valid &
                  ((dec_uses_rs1 & (dec_rs1_ad == ex_q.rd_ad)) |
                   (dec_uses_rs2 & (dec_rs2_ad == ex_q.rd_ad)));

  assign stall_fd = !flush_ex & (hazard | (state == STALL));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      state <= RUN;
      cnt   <= 3'd0;
    end else if (flush_ex) begin
      ex_q  <= '0;
      state <= RUN;
      cnt   <= 3'd0;
    end else if (state == STALL) begin
      // DEC is frozen here; its inputs are re-examined once back in RUN.
      ex_q <= '0;
      cnt  <= cnt - 3'd1;
      if (cnt == 3'd1) state <= RUN;
    end else if (hazard) begin
      ex_q <= '0;
      if (LOAD_USE_STALL > 1) begin
        state <= STALL;
        cnt   <= 3'(LOAD_USE_STALL - 1);
      end
    end else if (dec_valid) begin
      ex_q <= dec_pkt;
    end else begin
      ex_q <= '0;
    end
  end

  assign dec_ex_valid    = ex_q.valid;
  assign dec_ex_pc       = ex_q.pc;
  assign dec_ex_rs1_ad   = ex_q.rs1_ad;
  assign dec_ex_rs2_ad   = ex_q.rs2_ad;
  assign dec_ex_rd_ad    = ex_q.rd_ad;
  assign dec_ex_rs1_data = ex_q.rs1_data;
  assign dec_ex_rs2_data = ex_q.rs2_data;
  assign dec_ex_imm      = ex_q.imm;
  assign dec_ex_ctrl     = ex_q.ctrl;
  assign dec_ex_rdEn     = ex_q.rdEn;
  assign dec_ex_memRd    = ex_q.memRd;

endmodule

// File: tb/tb_dec_ex_stage.sv
// Directed bench for dec_ex_stage: one instance with a 1-cycle load-use stall, one with 3 cycles.
module tb_dec_ex_stage;
  localparam int XLEN = 32;
  localparam int CW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, dec_valid, dec_uses_rs1, dec_uses_rs2, dec_rdEn, dec_memRd, flush_ex;
  logic [XLEN-1:0] dec_pc, dec_rs1_data, dec_rs2_data, dec_imm;
  logic [4:0]      dec_rs1_ad, dec_rs2_ad, dec_rd_ad;
  logic [CW-1:0]   dec_ctrl;

  logic            a_valid, a_rdEn, a_memRd, a_stall;
  logic [XLEN-1:0] a_pc, a_d1, a_d2, a_imm;
  logic [4:0]      a_rs1, a_rs2, a_rd;
  logic [CW-1:0]   a_ctrl;
  logic            b_valid, b_rdEn, b_memRd, b_stall;
  logic [XLEN-1:0] b_pc, b_d1, b_d2, b_imm;
  logic [4:0]      b_rs1, b_rs2, b_rd;
  logic [CW-1:0]   b_ctrl;

  dec_ex_stage #(.XLEN(XLEN), .CTRL_W(CW), .LOAD_USE_STALL(1)) u1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_rs1_ad(dec_rs1_ad), .dec_rs2_ad(dec_rs2_ad), .dec_rd_ad(dec_rd_ad),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
    .dec_ctrl(dec_ctrl), .dec_rdEn(dec_rdEn), .dec_memRd(dec_memRd), .flush_ex(flush_ex),
    .dec_ex_valid(a_valid), .dec_ex_pc(a_pc), .dec_ex_rs1_ad(a_rs1), .dec_ex_rs2_ad(a_rs2),
    .dec_ex_rd_ad(a_rd), .dec_ex_rs1_data(a_d1), .dec_ex_rs2_data(a_d2), .dec_ex_imm(a_imm),
    .dec_ex_ctrl(a_ctrl), .dec_ex_rdEn(a_rdEn), .dec_ex_memRd(a_memRd), .stall_fd(a_stall));

  dec_ex_stage #(.XLEN(XLEN), .CTRL_W(CW), .LOAD_USE_STALL(3)) u3 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_rs1_ad(dec_rs1_ad), .dec_rs2_ad(dec_rs2_ad), .dec_rd_ad(dec_rd_ad),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
    .dec_ctrl(dec_ctrl), .dec_rdEn(dec_rdEn), .dec_memRd(dec_memRd), .flush_ex(flush_ex),
    .dec_ex_valid(b_valid), .dec_ex_pc(b_pc), .dec_ex_rs1_ad(b_rs1), .dec_ex_rs2_ad(b_rs2),
    .dec_ex_rd_ad(b_rd), .dec_ex_rs1_data(b_d1), .dec_ex_rs2_data(b_d2), .dec_ex_imm(b_imm),
    .dec_ex_ctrl(b_ctrl), .dec_ex_rdEn(b_rdEn), .dec_ex_memRd(b_memRd), .stall_fd(b_stall));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rs1/rs2/rd, uses flags, load/write flags, pc; data fields derived from pc so captures are traceable
  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1f, input logic u2f, input logic we, input logic ld,
                       input logic [31:0] pc);
    dec_valid    = v;
    dec_rs1_ad   = r1;
    dec_rs2_ad   = r2;
    dec_rd_ad    = rd;
    dec_uses_rs1 = u1f;
    dec_uses_rs2 = u2f;
    dec_rdEn     = we;
    dec_memRd    = ld;
    dec_pc       = pc;
    dec_rs1_data = pc ^ 32'h1111_0000;
    dec_rs2_data = pc ^ 32'h2222_0000;
    dec_imm      = pc ^ 32'h0000_00ff;
    dec_ctrl     = pc[7:0] ^ 8'h5a;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush_ex = 1'b0;
    // 1: reset with random inputs for two cycles
    drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, $urandom);
    step();
    drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, $urandom);
    step();
    chk("rst_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_pc", {32'd0, a_pc}, 64'd0);
    chk("rst_rd", {59'd0, a_rd}, 64'd0);
    chk("rst_ctrl", {56'd0, a_ctrl}, 64'd0);
    chk("rst_flags", {62'd0, a_rdEn, a_memRd}, 64'd0);
    chk("rst_data", {a_d1, a_imm}, 64'd0);
    chk("rst_stall", {62'd0, a_stall, b_stall}, 64'd0);
    chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
    rst = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
    step();
    chk("cap_valid", {63'd0, a_valid}, 64'd1);
    chk("cap_pc", {32'd0, a_pc}, 64'h100);
    chk("cap_regs", {49'd0, a_rs1, a_rs2, a_rd}, {49'd0, 5'd1, 5'd2, 5'd3});
    chk("cap_data", {a_d1, a_d2}, {32'h1111_0100, 32'h2222_0100});
    chk("cap_imm_ctrl", {24'd0, a_imm, a_ctrl}, {24'd0, 32'h1ff, 8'h5a});
    // invalid slot must not leak control
    drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104);
    step();
    chk("inv_bubble", {a_valid, a_rdEn, a_memRd, a_ctrl, a_pc}, 64'd0);

    // 2: lw x5 then add x6,x5,x7 with one stall cycle
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200);
    step();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h204);
    chk("lu1_stall", {63'd0, a_stall}, 64'd1);
    step();
    chk("lu1_bubble", {58'd0, a_valid, a_rs1}, 64'd0);
    chk("lu1_release", {63'd0, a_stall}, 64'd0);
    step();
    chk("lu1_add", {26'd0, a_valid, a_rs1, a_rd, a_pc}, {26'd0, 1'b1, 5'd5, 5'd6, 32'h204});

    // 3: same pair, three stall cycles
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300);
    step();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h304);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lu3_stall%0d", i), {63'd0, b_stall}, 64'd1);
      step();
      chk($sformatf("lu3_bubble%0d", i), {63'd0, b_valid}, 64'd0);
    end
    chk("lu3_release", {63'd0, b_stall}, 64'd0);
    step();
    chk("lu3_add", {26'd0, b_valid, b_rs1, b_rd, b_pc}, {26'd0, 1'b1, 5'd5, 5'd6, 32'h304});

    // 4: cases that must not stall
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h404);
    chk("x0_nostall", {63'd0, a_stall}, 64'd0);
    step();
    chk("x0_cap", {63'd0, a_valid}, 64'd1);
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h408);
    step();
    drive(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40c);
    chk("rs2_unused", {63'd0, a_stall}, 64'd0);
    step();
    drive(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h410);
    chk("load_in_mem", {63'd0, a_stall}, 64'd0);
    step();
    drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h414);
    chk("alu_writer", {63'd0, a_stall}, 64'd0);
    step();
    chk("alu_chain", {32'd0, a_pc}, 64'h414);

    // 5: flush on a hazard cycle
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h500);
    step();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h504);
    flush_ex = 1'b1;
    #1;
    chk("fl_stall", {62'd0, a_stall, b_stall}, 64'd0);
    step();
    flush_ex = 1'b0;
    chk("fl_bubble", {26'd0, a_valid, a_rd, a_pc}, 64'd0);
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h508);
    step();
    chk("fl_resume", {31'd0, a_valid, a_pc}, {31'd0, 1'b1, 32'h508});
    chk("fl_resume_b", {31'd0, b_valid, b_pc}, {31'd0, 1'b1, 32'h508});

    // 6: flush in the middle of a 3-cycle stall
    do_reset();
    drive(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h600);
    step();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h604);
    chk("mid_stall0", {63'd0, b_stall}, 64'd1);
    step();
    chk("mid_stall1", {63'd0, b_stall}, 64'd1);
    flush_ex = 1'b1;
    #1;
    chk("mid_flush", {63'd0, b_stall}, 64'd0);
    step();
    flush_ex = 1'b0;
    chk("mid_bubble", {63'd0, b_valid}, 64'd0);
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h608);
    chk("mid_run", {63'd0, b_stall}, 64'd0);
    step();
    chk("mid_resume", {31'd0, b_valid, b_pc}, {31'd0, 1'b1, 32'h608});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
